// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register for the pipelined MIPS core. It also produces the ALU operand
// forwarding selects and the load-use stall request for the ID/EX stage.
module ex_mem_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_valid,
    input  logic [DATA_W-1:0] ex_alu_out,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_reg_write,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic              ex_mem_to_reg,
    input  logic              stall,
    input  logic              flush,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] idex_rs,
    input  logic [REG_AW-1:0] idex_rt,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_reg_write,
    output logic              mem_valid,
    output logic [DATA_W-1:0] mem_alu_out,
    output logic [DATA_W-1:0] mem_store_data,
    output logic [REG_AW-1:0] mem_rd,
    output logic              mem_reg_write,
    output logic              mem_mem_read,
    output logic              mem_mem_write,
    output logic              mem_mem_to_reg,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              load_use_stall,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic              r_valid;
    logic [DATA_W-1:0] r_alu_out;
    logic [DATA_W-1:0] r_store_data;
    logic [REG_AW-1:0] r_rd;
    logic              r_reg_write;
    logic              r_mem_read;
    logic              r_mem_write;
    logic              r_mem_to_reg;
    logic [CNT_W-1:0]  r_bubble_cnt;

    // A load sitting in EX/MEM has no data yet, so only non-load writers forward from here.
    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src);
        logic ex_hit;
        logic wb_hit;
        ex_hit = r_reg_write && !r_mem_to_reg && (r_rd != '0) && (r_rd == src);
        wb_hit = wb_reg_write && (wb_rd != '0) && (wb_rd == src);
        if (ex_hit)
            fwd_sel = 2'b10;
        else if (wb_hit)
            fwd_sel = 2'b01;
        else
            fwd_sel = 2'b00;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid      <= 1'b0;
            r_alu_out    <= '0;
            r_store_data <= '0;
            r_rd         <= '0;
            r_reg_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_bubble_cnt <= '0;
        end else if (flush) begin
            // Bubble: kill valid and controls, leave data fields as they were.
            r_valid      <= 1'b0;
            r_reg_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_bubble_cnt <= r_bubble_cnt + 1'b1;
        end else if (!stall) begin
            r_valid      <= ex_valid;
            r_alu_out    <= ex_alu_out;
            r_store_data <= ex_store_data;
            r_rd         <= ex_rd;
            r_reg_write  <= ex_valid & ex_reg_write;
            r_mem_read   <= ex_valid & ex_mem_read;
            r_mem_write  <= ex_valid & ex_mem_write;
            r_mem_to_reg <= ex_valid & ex_mem_to_reg;
            if (!ex_valid)
                r_bubble_cnt <= r_bubble_cnt + 1'b1;
        end
    end

    always_comb begin
        fwd_a          = fwd_sel(idex_rs);
        fwd_b          = fwd_sel(idex_rt);
        load_use_stall = ex_valid && ex_mem_read && (ex_rd != '0)
                         && ((ex_rd == id_rs) || (ex_rd == id_rt));
    end

    assign mem_valid      = r_valid;
    assign mem_alu_out    = r_alu_out;
    assign mem_store_data = r_store_data;
    assign mem_rd         = r_rd;
    assign mem_reg_write  = r_reg_write;
    assign mem_mem_read   = r_mem_read;
    assign mem_mem_write  = r_mem_write;
    assign mem_mem_to_reg = r_mem_to_reg;
    assign bubble_cnt     = r_bubble_cnt;

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- EX/MEM pipeline register for the pipelined MIPS core. Sits directly downstream of the ALU.
- Captures the ALU result, store data, destination register and memory/writeback controls each cycle, and presents them to the data-memory stage.
- Also produces the ALU operand forwarding selects and the load-use stall request for the ID/EX stage.

Parameters:
- DATA_W, 32, datapath width (ALU result, store data)
- REG_AW, 5, register-index width
- CNT_W, 16, width of the bubble counter

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- ex_valid  in  1  EX stage holds a real instruction
- ex_alu_out  in  DATA_W  ALU result (address for lw/sw)
- ex_store_data  in  DATA_W  forwarded rt value for sw
- ex_rd  in  REG_AW  destination register
- ex_reg_write  in  1  instruction writes the register file
- ex_mem_read  in  1  lw
- ex_mem_write  in  1  sw
- ex_mem_to_reg  in  1  writeback from memory
- stall  in  1  hold EX/MEM contents
- flush  in  1  insert bubble
- id_rs  in  REG_AW  rs of instruction in ID
- id_rt  in  REG_AW  rt of instruction in ID
- idex_rs  in  REG_AW  rs of instruction entering ALU
- idex_rt  in  REG_AW  rt of instruction entering ALU
- wb_rd  in  REG_AW  MEM/WB destination
- wb_reg_write  in  1  MEM/WB write enable (already valid-gated)
- mem_valid  out  1  registered valid
- mem_alu_out  out  DATA_W  registered ALU result
- mem_store_data  out  DATA_W  registered store data
- mem_rd  out  REG_AW  registered destination
- mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg  out  1 each  registered controls, forced 0 when mem_valid=0
- fwd_a  out  2  ALU in1 select: 00 regfile, 10 EX/MEM, 01 MEM/WB
- fwd_b  out  2  ALU in2 select, same encoding
- load_use_stall  out  1  combinational stall request to the hazard unit
- bubble_cnt  out  CNT_W  count of bubbles entered into the MEM stage

Behaviour:
- Reset (reset=1 at a rising edge): every registered output goes to 0, including bubble_cnt. reset has priority over flush and stall.
- Normal capture (no stall, no flush): one-cycle latency. All mem_* outputs take their ex_* values. mem_valid <= ex_valid.
- Control gating: when ex_valid=0 the captured reg_write, mem_read, mem_write and mem_to_reg are 0. Data fields are don't-care but captured anyway.
- stall=1, flush=0: all mem_* registers hold their values. bubble_cnt holds.
- flush=1: mem_valid and all mem control bits <= 0. Data registers hold. flush wins over stall.
- bubble_cnt: increments by 1 on each non-reset edge where the newly loaded mem_valid=0. This covers a flush, or a capture with ex_valid=0. It wraps from 2^CNT_W-1 to 0. It does not increment while stalled.
- Forwarding, computed from the current registered state:
  - ex_hit_a = mem_reg_write & !mem_mem_to_reg & (mem_rd!=0) & (mem_rd==idex_rs).
  - wb_hit_a = wb_reg_write & (wb_rd!=0) & (wb_rd==idex_rs).
  - fwd_a = ex_hit_a ? 10 : wb_hit_a ? 01 : 00. The EX/MEM source has priority over MEM/WB.
  - fwd_b is the same with idex_rt.
- Register 0 never forwards.
- A load in EX/MEM never forwards from EX/MEM, because its data is not yet available. The load-use stall covers this case.
- load_use_stall = ex_valid & ex_mem_read & (ex_rd!=0) & ((ex_rd==id_rs) | (ex_rd==id_rt)). It is purely combinational and is not affected by stall, flush or reset.
- Simultaneous stall with ex_valid=1: the EX instruction is not captured. Upstream must hold it.
- Reset mid-stall: the pipeline is cleared and the next non-reset edge captures normally.

Test Plan:
- Reset → pulse reset with ex_valid=1, ex_alu_out=32'h1234 → all outputs 0 after the edge. The next edge captures mem_alu_out=32'h1234, mem_valid=1.
- add r3 flows: ex_alu_out=32'd7, ex_rd=3, ex_reg_write=1; next cycle idex_rs=3 → fwd_a=10. With wb_rd=3 and wb_reg_write=1 also set, fwd_a stays 10. With mem_rd=0, fwd_a=00.
- lw r5 in EX (ex_mem_read=1, ex_rd=5), id_rt=5 → load_use_stall=1. After capture with idex_rt=5, fwd_b=00 because mem_mem_to_reg=1 blocks forwarding. With wb_rd=5 and wb_reg_write=1, fwd_b=01.
- stall held 3 cycles with ex_alu_out changing 1,2,3 → mem_alu_out keeps its prior value 32'hAA and bubble_cnt is unchanged. Assert flush together with stall → mem_valid=0, mem_reg_write=0, bubble_cnt+1.
- sw with ex_valid=0 (ex_mem_write=1, ex_store_data=32'hDEAD) → mem_mem_write=0, mem_valid=0, bubble_cnt increments.
- Set CNT_W=4 and drive 17 bubbles from reset → bubble_cnt sequences 1..15, 0, 1.
